rv_decode_stage: RTL and testbench

Registered, parametrised RISC-V instruction decode stage. It extends plain field extraction with:
- format classification
- sign-extended immediate generation for RV32I/RV64I
- register-use flags and illegal-opcode detection
- a ready/valid pipeline register with flush
- saturating decode and illegal-instruction counters

It sits between the fetch stage and the register-read/hazard stage.

---
 rtl/rv_decode_stage.sv | 199 +++++++++++++++++++
 tb/tb_rv_decode_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32I/RV64I instruction decode stage.
// Classifies the opcode, builds the sign-extended immediate, flags register
// usage and illegal words, and holds the result in a ready/valid pipeline
// register with flush. Saturating counters track transfers and illegal ones.
module rv_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       op_code,
  output logic [4:0]       dest_reg,
  output logic [4:0]       src_reg_1,
  output logic [4:0]       src_reg_2,
  output logic [2:0]       fn3,
  output logic [6:0]       fn7,
  output logic [2:0]       fmt,
  output logic [XLEN-1:0]  imm,
  output logic             rd_en,
  output logic             rs1_en,
  output logic             rs2_en,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_cnt,
  output logic [CNT_W-1:0] ill_cnt
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // W-opcodes only exist in the 64-bit configuration
  localparam logic RV64 = (XLEN == 64);

  logic [2:0]      w_fmt;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_rd_en;
  logic            w_rs1_en;
  logic            w_rs2_en;
  logic            w_illegal;
  logic            w_accept;
  logic            w_xfer;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [2:0]      r_fmt;
  logic [XLEN-1:0] r_imm;
  logic            r_rd_en;
  logic            r_rs1_en;
  logic            r_rs2_en;
  logic            r_illegal;
  logic [CNT_W-1:0] r_dec;
  logic [CNT_W-1:0] r_ill;

  // Classify the incoming opcode into an instruction format
  always_comb begin
    w_fmt = FMT_ILL;
    case (in_instr[6:0])
      OP_OP:    w_fmt = FMT_R;
      OP_OP32: begin
        if (RV64) w_fmt = FMT_R;
        else      w_fmt = FMT_ILL;
      end
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: w_fmt = FMT_I;
      OP_IMM32: begin
        if (RV64) w_fmt = FMT_I;
        else      w_fmt = FMT_ILL;
      end
      OP_STORE:        w_fmt = FMT_S;
      OP_BRANCH:       w_fmt = FMT_B;
      OP_LUI, OP_AUIPC: w_fmt = FMT_U;
      OP_JAL:          w_fmt = FMT_J;
      default:         w_fmt = FMT_ILL;
    endcase
  end

  // Assemble the 32-bit immediate per format, then sign-extend to XLEN
  always_comb begin
    w_imm32 = 32'd0;
    case (w_fmt)
      FMT_I:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U:   w_imm32 = {in_instr[31:12], 12'd0};
      FMT_J:   w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      default: w_imm32 = 32'd0;
    endcase
    w_imm        = {XLEN{w_imm32[31]}};
    w_imm[31:0]  = w_imm32;
  end

  // Register-use flags follow the format; illegal words use no registers
  always_comb begin
    w_rd_en  = 1'b0;
    w_rs1_en = 1'b0;
    w_rs2_en = 1'b0;
    case (w_fmt)
      FMT_R:   begin w_rd_en = 1'b1; w_rs1_en = 1'b1; w_rs2_en = 1'b1; end
      FMT_I:   begin w_rd_en = 1'b1; w_rs1_en = 1'b1; w_rs2_en = 1'b0; end
      FMT_S,
      FMT_B:   begin w_rd_en = 1'b0; w_rs1_en = 1'b1; w_rs2_en = 1'b1; end
      FMT_U,
      FMT_J:   begin w_rd_en = 1'b1; w_rs1_en = 1'b0; w_rs2_en = 1'b0; end
      default: begin w_rd_en = 1'b0; w_rs1_en = 1'b0; w_rs2_en = 1'b0; end
    endcase
  end

  // Any recognised opcode already carries instr[1:0] == 2'b11
  assign w_illegal = (w_fmt == FMT_ILL);

  assign in_ready = !rst && !flush && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = r_valid && out_ready;

  // Pipeline register: load on accept, drain on transfer or flush, else hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_pc      <= {XLEN{1'b0}};
      r_instr   <= 32'd0;
      r_fmt     <= 3'd0;
      r_imm     <= {XLEN{1'b0}};
      r_rd_en   <= 1'b0;
      r_rs1_en  <= 1'b0;
      r_rs2_en  <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_pc      <= in_pc;
      r_instr   <= in_instr;
      r_fmt     <= w_fmt;
      r_imm     <= w_imm;
      r_rd_en   <= w_rd_en;
      r_rs1_en  <= w_rs1_en;
      r_rs2_en  <= w_rs2_en;
      r_illegal <= w_illegal;
    end else if (w_xfer || flush) begin
      r_valid   <= 1'b0;
    end
  end

  // Saturating statistics; a transfer during flush still counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dec <= {CNT_W{1'b0}};
      r_ill <= {CNT_W{1'b0}};
    end else if (w_xfer) begin
      if (r_dec != {CNT_W{1'b1}}) r_dec <= r_dec + CNT_W'(1);
      if (r_illegal && (r_ill != {CNT_W{1'b1}})) r_ill <= r_ill + CNT_W'(1);
    end
  end

  assign out_valid = r_valid;
  assign out_pc    = r_pc;
  assign op_code   = r_instr[6:0];
  assign dest_reg  = r_instr[11:7];
  assign fn3       = r_instr[14:12];
  assign src_reg_1 = r_instr[19:15];
  assign src_reg_2 = r_instr[24:20];
  assign fn7       = r_instr[31:25];
  assign fmt       = r_fmt;
  assign imm       = r_imm;
  assign rd_en     = r_rd_en;
  assign rs1_en    = r_rs1_en;
  assign rs2_en    = r_rs2_en;
  assign illegal   = r_illegal;
  assign dec_cnt   = r_dec;
  assign ill_cnt   = r_ill;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: three instances (XLEN=32, XLEN=64,
// XLEN=32 with 4-bit counters) share one input stream.
module tb_rv_decode_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic a_in_ready, a_out_valid, a_rd_en, a_rs1_en, a_rs2_en, a_illegal;
  logic [31:0] a_out_pc, a_imm;
  logic [6:0]  a_op_code, a_fn7;
  logic [4:0]  a_dest_reg, a_src_reg_1, a_src_reg_2;
  logic [2:0]  a_fn3, a_fmt;
  logic [15:0] a_dec_cnt, a_ill_cnt;

  logic b_in_ready, b_out_valid, b_rd_en, b_rs1_en, b_rs2_en, b_illegal;
  logic [63:0] b_out_pc, b_imm;
  logic [6:0]  b_op_code, b_fn7;
  logic [4:0]  b_dest_reg, b_src_reg_1, b_src_reg_2;
  logic [2:0]  b_fn3, b_fmt;
  logic [15:0] b_dec_cnt, b_ill_cnt;

  logic c_in_ready, c_out_valid, c_rd_en, c_rs1_en, c_rs2_en, c_illegal;
  logic [31:0] c_out_pc, c_imm;
  logic [6:0]  c_op_code, c_fn7;
  logic [4:0]  c_dest_reg, c_src_reg_1, c_src_reg_2;
  logic [2:0]  c_fn3, c_fmt;
  logic [3:0]  c_dec_cnt, c_ill_cnt;

  int pass_cnt;
  int total_cnt;

  rv_decode_stage #(.XLEN(32), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .op_code(a_op_code), .dest_reg(a_dest_reg), .src_reg_1(a_src_reg_1),
    .src_reg_2(a_src_reg_2), .fn3(a_fn3), .fn7(a_fn7), .fmt(a_fmt), .imm(a_imm),
    .rd_en(a_rd_en), .rs1_en(a_rs1_en), .rs2_en(a_rs2_en), .illegal(a_illegal),
    .dec_cnt(a_dec_cnt), .ill_cnt(a_ill_cnt));

  rv_decode_stage #(.XLEN(64), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .op_code(b_op_code), .dest_reg(b_dest_reg), .src_reg_1(b_src_reg_1),
    .src_reg_2(b_src_reg_2), .fn3(b_fn3), .fn7(b_fn7), .fmt(b_fmt), .imm(b_imm),
    .rd_en(b_rd_en), .rs1_en(b_rs1_en), .rs2_en(b_rs2_en), .illegal(b_illegal),
    .dec_cnt(b_dec_cnt), .ill_cnt(b_ill_cnt));

  rv_decode_stage #(.XLEN(32), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_pc(c_out_pc), .op_code(c_op_code), .dest_reg(c_dest_reg), .src_reg_1(c_src_reg_1),
    .src_reg_2(c_src_reg_2), .fn3(c_fn3), .fn7(c_fn7), .fmt(c_fmt), .imm(c_imm),
    .rd_en(c_rd_en), .rs1_en(c_rs1_en), .rs2_en(c_rs2_en), .illegal(c_illegal),
    .dec_cnt(c_dec_cnt), .ill_cnt(c_ill_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", a_out_valid); else pass_cnt++;
    total_cnt++; if (a_in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b want 0", a_in_ready); else pass_cnt++;
    total_cnt++; if ({a_fmt, a_imm, a_dest_reg, a_rd_en} !== 41'd0) $display("FAIL reset_data: got fmt=%0d imm=%h rd=%0d", a_fmt, a_imm, a_dest_reg); else pass_cnt++;
    total_cnt++; if ({a_dec_cnt, a_ill_cnt, b_imm} !== 96'd0) $display("FAIL reset_cnt: got dec=%0d ill=%0d", a_dec_cnt, a_ill_cnt); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL reset_release_ready: got %0b want 1", a_in_ready); else pass_cnt++;
  endtask

  task automatic test_basic();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 64'h0000_0001_0000_0100;
    #1;
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL basic_latency: got out_valid=%0b want 0", a_out_valid); else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    total_cnt++; if (a_out_valid !== 1'b1) $display("FAIL basic_valid: got %0b want 1", a_out_valid); else pass_cnt++;
    total_cnt++; if (a_fmt !== 3'd0) $display("FAIL basic_fmt: got %0d want 0", a_fmt); else pass_cnt++;
    total_cnt++; if ({a_dest_reg, a_src_reg_1, a_src_reg_2} !== {5'd3, 5'd1, 5'd2}) $display("FAIL basic_regs: got %0d %0d %0d want 3 1 2", a_dest_reg, a_src_reg_1, a_src_reg_2); else pass_cnt++;
    total_cnt++; if (a_imm !== 32'd0) $display("FAIL basic_imm: got %h want 0", a_imm); else pass_cnt++;
    total_cnt++; if ({a_rd_en, a_rs1_en, a_rs2_en} !== 3'b111) $display("FAIL basic_en: got %b want 111", {a_rd_en, a_rs1_en, a_rs2_en}); else pass_cnt++;
    total_cnt++; if (a_out_pc !== 32'h0000_0100 || b_out_pc !== 64'h0000_0001_0000_0100) $display("FAIL basic_pc: got %h / %h", a_out_pc, b_out_pc); else pass_cnt++;
    total_cnt++; if ({a_op_code, a_fn3, a_fn7} !== {7'h33, 3'd0, 7'd0}) $display("FAIL basic_fields: got op=%h f3=%0d f7=%0d", a_op_code, a_fn3, a_fn7); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (a_dec_cnt !== 16'd1 || a_out_valid !== 1'b0) $display("FAIL basic_drain: got dec=%0d valid=%0b want 1 0", a_dec_cnt, a_out_valid); else pass_cnt++;
  endtask

  task automatic test_imm_back_to_back();
    logic [31:0] ins [5];
    logic [2:0]  ef  [5];
    logic [31:0] e32 [5];
    logic [63:0] e64 [5];
    logic [2:0]  een [5];
    ins[0] = 32'hFFF00093; ef[0] = 3'd1; e32[0] = 32'hFFFFFFFF; e64[0] = 64'hFFFF_FFFF_FFFF_FFFF; een[0] = 3'b110;
    ins[1] = 32'h0020A423; ef[1] = 3'd2; e32[1] = 32'h00000008; e64[1] = 64'h0000_0000_0000_0008; een[1] = 3'b011;
    ins[2] = 32'hFE208EE3; ef[2] = 3'd3; e32[2] = 32'hFFFFFFFC; e64[2] = 64'hFFFF_FFFF_FFFF_FFFC; een[2] = 3'b011;
    ins[3] = 32'h001000EF; ef[3] = 3'd5; e32[3] = 32'h00000800; e64[3] = 64'h0000_0000_0000_0800; een[3] = 3'b100;
    ins[4] = 32'h800000B7; ef[4] = 3'd4; e32[4] = 32'h80000000; e64[4] = 64'hFFFF_FFFF_8000_0000; een[4] = 3'b100;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total_cnt++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b1) $display("FAIL b2b_valid[%0d]: got valid=%0b ready=%0b want 1 1", i-1, a_out_valid, a_in_ready); else pass_cnt++;
        total_cnt++; if (a_fmt !== ef[i-1] || b_fmt !== ef[i-1]) $display("FAIL imm_fmt[%0d]: got %0d/%0d want %0d", i-1, a_fmt, b_fmt, ef[i-1]); else pass_cnt++;
        total_cnt++; if (a_imm !== e32[i-1]) $display("FAIL imm32[%0d]: got %h want %h", i-1, a_imm, e32[i-1]); else pass_cnt++;
        total_cnt++; if (b_imm !== e64[i-1]) $display("FAIL imm64[%0d]: got %h want %h", i-1, b_imm, e64[i-1]); else pass_cnt++;
        total_cnt++; if ({a_rd_en, a_rs1_en, a_rs2_en} !== een[i-1]) $display("FAIL imm_en[%0d]: got %b want %b", i-1, {a_rd_en, a_rs1_en, a_rs2_en}, een[i-1]); else pass_cnt++;
        if (i == 4) begin
          total_cnt++; if (a_dest_reg !== 5'd1) $display("FAIL jal_rd: got %0d want 1", a_dest_reg); else pass_cnt++;
        end
      end
      if (i < 5) begin
        in_valid = 1'b1; in_instr = ins[i];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    total_cnt++; if (a_dec_cnt !== 16'd6 || a_out_valid !== 1'b0) $display("FAIL b2b_count: got dec=%0d valid=%0b want 6 0", a_dec_cnt, a_out_valid); else pass_cnt++;
  endtask

  task automatic test_illegal();
    logic [31:0] ins [3];
    logic [2:0]  bf  [3];
    ins[0] = 32'h00000000; bf[0] = 3'd7;
    ins[1] = 32'h0000007B; bf[1] = 3'd7;
    ins[2] = 32'h0000003B; bf[2] = 3'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total_cnt++; if (a_illegal !== 1'b1 || a_fmt !== 3'd7) $display("FAIL ill32[%0d]: got ill=%0b fmt=%0d want 1 7", i-1, a_illegal, a_fmt); else pass_cnt++;
        total_cnt++; if ({a_rd_en, a_rs1_en, a_rs2_en} !== 3'b000) $display("FAIL ill32_en[%0d]: got %b want 000", i-1, {a_rd_en, a_rs1_en, a_rs2_en}); else pass_cnt++;
        total_cnt++; if (b_fmt !== bf[i-1] || b_illegal !== (bf[i-1] == 3'd7)) $display("FAIL ill64[%0d]: got fmt=%0d ill=%0b want fmt %0d", i-1, b_fmt, b_illegal, bf[i-1]); else pass_cnt++;
      end
      if (i < 3) begin
        in_valid = 1'b1; in_instr = ins[i];
      end else begin
        in_valid = 1'b0;
      end
    end
    total_cnt++; if ({b_rd_en, b_rs1_en, b_rs2_en} !== 3'b111) $display("FAIL rv64_w_en: got %b want 111", {b_rd_en, b_rs1_en, b_rs2_en}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (a_ill_cnt !== 16'd3 || b_ill_cnt !== 16'd2 || a_dec_cnt !== 16'd9) $display("FAIL ill_cnt: got a=%0d b=%0d dec=%0d want 3 2 9", a_ill_cnt, b_ill_cnt, a_dec_cnt); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int  p;
    int  q;
    logic took;
    do_reset();
    p = 0; q = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c < 5);
      in_valid = (p < 4);
      if (p < 4) in_instr = {12'(p + 1), 5'd0, 3'd0, 5'(p + 1), 7'h13};
      #1;
      if (!out_ready) begin
        total_cnt++; if (a_in_ready !== 1'b0) $display("FAIL stall_ready[%0d]: got %0b want 0", c, a_in_ready); else pass_cnt++;
        total_cnt++; if (a_out_valid !== 1'b1 || a_dest_reg !== 5'(q + 1) || a_imm !== 32'(q + 1)) $display("FAIL stall_hold[%0d]: got valid=%0b rd=%0d want 1 %0d", c, a_out_valid, a_dest_reg, q + 1); else pass_cnt++;
      end
      took = in_valid && a_in_ready;
      if (a_out_valid && out_ready) begin
        total_cnt++; if (a_dest_reg !== 5'(q + 1) || a_imm !== 32'(q + 1)) $display("FAIL bp_order[%0d]: got rd=%0d want %0d", c, a_dest_reg, q + 1); else pass_cnt++;
        q++;
      end
      if (took) p++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if (q !== 4 || a_dec_cnt !== 16'd4 || a_out_valid !== 1'b0) $display("FAIL bp_total: got recv=%0d dec=%0d want 4 4", q, a_dec_cnt); else pass_cnt++;
  endtask

  task automatic test_flush();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h002081B3;
    @(negedge clk);
    in_instr = 32'hFFF00093; flush = 1'b1;
    #1;
    total_cnt++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) $display("FAIL flush_ready: got ready=%0b valid=%0b want 0 1", a_in_ready, a_out_valid); else pass_cnt++;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL flush_valid: got %0b want 0", a_out_valid); else pass_cnt++;
    total_cnt++; if (a_fmt !== 3'd0 || a_dest_reg !== 5'd3) $display("FAIL flush_data_kept: got fmt=%0d rd=%0d want 0 3", a_fmt, a_dest_reg); else pass_cnt++;
    total_cnt++; if (a_dec_cnt !== 16'd4) $display("FAIL flush_cnt: got %0d want 4", a_dec_cnt); else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h002081B3;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total_cnt++; if (a_out_valid !== 1'b0 || a_dec_cnt !== 16'd5) $display("FAIL flush_xfer: got valid=%0b dec=%0d want 0 5", a_out_valid, a_dec_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 64'h0000_0000_0000_0200;
    @(negedge clk);
    in_valid = 1'b0;
    total_cnt++; if (a_out_valid !== 1'b1) $display("FAIL mid_held: got %0b want 1", a_out_valid); else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    total_cnt++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0) $display("FAIL mid_rst_hs: got valid=%0b ready=%0b want 0 0", a_out_valid, a_in_ready); else pass_cnt++;
    total_cnt++; if ({a_fmt, a_imm, a_dest_reg, a_out_pc, b_imm} !== 136'd0) $display("FAIL mid_rst_data: got fmt=%0d imm=%h pc=%h", a_fmt, a_imm, a_out_pc); else pass_cnt++;
    total_cnt++; if (a_dec_cnt !== 16'd0 || a_ill_cnt !== 16'd0) $display("FAIL mid_rst_cnt: got dec=%0d ill=%0d want 0 0", a_dec_cnt, a_ill_cnt); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL mid_release: got %0b want 1", a_in_ready); else pass_cnt++;
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = 32'h00000000;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (c_dec_cnt !== 4'hF || c_ill_cnt !== 4'hF) $display("FAIL sat_cnt: got dec=%0d ill=%0d want 15 15", c_dec_cnt, c_ill_cnt); else pass_cnt++;
    total_cnt++; if (a_dec_cnt !== 16'd20 || a_ill_cnt !== 16'd20) $display("FAIL wide_cnt: got dec=%0d ill=%0d want 20 20", a_dec_cnt, a_ill_cnt); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = 64'd0;
    test_reset();
    test_basic();
    test_imm_back_to_back();
    test_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
